pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter SEG, default 16, meaning bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG; STAGES = WIDTH/SEG.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operands present this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 The block SHALL have port a  input  WIDTH  first operand.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port cin  input  1  carry-in, used when sub=0.
REQ-010 The block SHALL have port sub  input  1  1 = subtract (a - b).
REQ-011 The block SHALL have port out_valid  output  1  result/cout valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 The block SHALL have port result  output  WIDTH  sum or difference.
REQ-014 The block SHALL have port cout  output  1  carry-out of MSB (borrow-not when sub=1).
REQ-015 The block SHALL have port overflow  output  1  signed overflow flag (see Configuration).
REQ-016 The block SHALL use one clock, clk; its reset rst_n SHALL be asynchronous and active-low.

Function
REQ-017 The block SHALL compute result = a + b + cin with sub=0, and a + ~b + 1 with sub=1, where cin is ignored; all arithmetic is modulo 2^WIDTH and cout is bit WIDTH of the full sum.
REQ-018 Each stage SHALL add one SEG-bit segment using carry-lookahead (generate/propagate, prefix carries), least-significant segment first; the segment carry-out SHALL be registered into the next stage.
REQ-019 Unprocessed upper operand segments and completed lower result segments SHALL travel with their transaction through the pipeline registers.
REQ-020 A transfer SHALL occur on a rising clk edge where valid and ready are both 1, on either side.
REQ-021 in_ready SHALL equal !(out_valid && !out_ready); when in_ready=0, all stages SHALL hold (global stall) and no data or valid bit SHALL change.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when no stall occurs; throughput SHALL be one transaction per cycle.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 on an enabled cycle) SHALL propagate as invalid slots and SHALL NOT stall the pipeline.
REQ-024 Operand, sub and cin values SHALL be sampled only at the input transfer; later changes SHALL NOT affect in-flight transactions.
REQ-025 result, cout and overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Simultaneous output transfer and input transfer in the same cycle SHALL be allowed with no lost or duplicated transaction.
REQ-027 With STAGES=1, the block SHALL be a single-register adder with latency 1.

Reset
REQ-028 On rst_n=0, all stage valid bits, out_valid, result, cout and overflow SHALL go to 0 immediately, without waiting for clk.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight transactions; the first transfer after release SHALL take full latency.

Configuration
REQ-031 With macro CLA_OVERFLOW_EN defined, overflow SHALL equal the carry into the MSB XOR cout, valid with out_valid.
REQ-032 Without CLA_OVERFLOW_EN, overflow SHALL be tied 0 and no overflow logic or register SHALL be synthesized.

Verification
REQ-033 WIDTH=64, SEG=16: a=0xFFFFFFFFFFFFFFFF, b=0, cin=1, sub=0 -> out_valid 4 cycles later; result=0, cout=1 (carry ripples through all stages).
REQ-034 a=5, b=7, sub=1, cin=1 -> result=0xFFFFFFFFFFFFFFFE, cout=0; same with a=7, b=5 -> result=2, cout=1.
REQ-035 Overflow case: a=0x7FFFFFFFFFFFFFFF, b=1, sub=0, cin=0 -> result=0x8000000000000000; overflow=1 with CLA_OVERFLOW_EN, 0 without.
REQ-036 Backpressure: 10 back-to-back random inputs with out_ready=0 for cycles 6-9 -> in_ready=0 exactly while out_valid&&!out_ready; all 10 results in order, matching a reference model.
REQ-037 Assert rst_n=0 with 3 transactions in flight -> out_valid=0 asynchronously; no stale result appears after release.
REQ-038 Parameter sweep WIDTH=8/SEG=8 and WIDTH=32/SEG=4 with 1000 random transactions -> latency STAGES, results match the reference model.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit segment per stage, LSB segment first.
// Optional macro CLA_OVERFLOW_EN adds a registered signed-overflow flag; otherwise overflow is tied 0.
module pipelined_cla_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;

  // Returns {carry_out, sum}; every carry is a flattened lookahead term of g/p and c0.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           c0);
    logic [SEG-1:0] g, p;
    logic [SEG:0]   c;
    logic           prod, term;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = c0;
    for (int i = 0; i < SEG; i++) begin
      term = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (g[j] & prod);
        prod = prod & p[j];
      end
      c[i+1] = term | (c0 & prod);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  // Index k feeds stage k; operands are not needed after the last stage.
  logic [WIDTH-1:0] a_p [STAGES];
  logic [WIDTH-1:0] b_p [STAGES];
  logic [WIDTH-1:0] s_p [STAGES+1];
  logic             c_p [STAGES+1];
  logic             v_p [STAGES+1];

  assign in_ready = !(out_valid && !out_ready);

  assign a_p[0] = a;
  assign b_p[0] = sub ? ~b : b;
  assign c_p[0] = sub ? 1'b1 : cin;
  assign s_p[0] = '0;
  assign v_p[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]     seg;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    always_comb begin
      seg   = cla_seg(a_p[k][k*SEG +: SEG], b_p[k][k*SEG +: SEG], c_p[k]);
      s_nxt = s_p[k];
      s_nxt[k*SEG +: SEG] = seg[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (in_ready) begin
        v_q <= v_p[k];
        s_q <= s_nxt;
        c_q <= seg[SEG];
      end
    end

    assign v_p[k+1] = v_q;
    assign s_p[k+1] = s_q;
    assign c_p[k+1] = c_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (in_ready) begin
          a_q <= a_p[k];
          b_q <= b_p[k];
        end
      end
      assign a_p[k+1] = a_q;
      assign b_p[k+1] = b_q;
    end

`ifdef CLA_OVERFLOW_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      // Carry into the MSB is recovered as p[msb] ^ sum[msb].
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ovf_q <= 1'b0;
        else if (in_ready)
          ovf_q <= a_p[k][WIDTH-1] ^ b_p[k][WIDTH-1] ^ seg[SEG-1] ^ seg[SEG];
      end
      assign overflow = ovf_q;
    end
`endif
  end

`ifndef CLA_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

  assign out_valid = v_p[STAGES];
  assign result    = s_p[STAGES];
  assign cout      = c_p[STAGES];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: three adder configurations (64/16, 8/8, 32/4) share one randomized stimulus stream;
// each accepted input pushes a reference-model expectation, a monitor pops on each output transfer.
module tb_pipelined_cla_adder;

  localparam int WV[3]  = '{64, 8, 32};
  localparam int STG[3] = '{4, 1, 8};

  typedef struct {
    logic [63:0] res;
    logic        co;
    logic        ov;
    longint      t;
    int          snap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        done;

  logic        irdy [3];
  logic        ovld [3];
  logic        co   [3];
  logic        of   [3];
  logic [63:0] res  [3];
  logic [63:0] r0;
  logic [7:0]  r1;
  logic [31:0] r2;

  exp_t        sbq [3][$];
  int          stall [3];
  logic        prev_stall [3];
  logic [63:0] prev_res [3];
  logic        prev_co [3];
  logic        prev_of [3];

  int checks;
  int errors;

  assign res[0] = r0;
  assign res[1] = {56'd0, r1};
  assign res[2] = {32'd0, r2};

  pipelined_cla_adder #(.WIDTH(64), .SEG(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ovld[0]), .out_ready(out_ready), .result(r0), .cout(co[0]), .overflow(of[0]));

  pipelined_cla_adder #(.WIDTH(8), .SEG(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ovld[1]), .out_ready(out_ready), .result(r1), .cout(co[1]), .overflow(of[1]));

  pipelined_cla_adder #(.WIDTH(32), .SEG(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(ovld[2]), .out_ready(out_ready), .result(r2), .cout(co[2]), .overflow(of[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain modular arithmetic on a WIDTH+1 bit sum.
  function automatic exp_t model(input int i, input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic sb);
    exp_t        e;
    int          w;
    logic [63:0] mask, xx, yy;
    logic [64:0] full;
    w    = WV[i];
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    xx   = x & mask;
    yy   = (sb ? ~y : y) & mask;
    full = {1'b0, xx} + {1'b0, yy} + (sb ? 65'd1 : 65'(ci));
    e.res = full[63:0] & mask;
    e.co  = full[w];
`ifdef CLA_OVERFLOW_EN
    e.ov  = (xx[w-1] == yy[w-1]) && (e.res[w-1] != xx[w-1]);
`else
    e.ov  = 1'b0;
`endif
    e.t    = longint'($time);
    e.snap = stall[i];
    return e;
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL d%0d %s: got %h expected %h at %0t", i, nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && in_valid)
      for (int i = 0; i < 3; i++)
        if (irdy[i]) sbq[i].push_back(model(i, a, b, cin, sub));
  end

  initial begin
    exp_t e;
    int   lat;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      stall[i] = 0;
      prev_stall[i] = 1'b0;
    end
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int i = 0; i < 3; i++) begin
          chk("reset out_valid", i, 64'(ovld[i]), 64'd0);
          chk("reset result", i, res[i], 64'd0);
          chk("reset cout", i, 64'(co[i]), 64'd0);
          chk("reset overflow", i, 64'(of[i]), 64'd0);
          chk("reset in_ready", i, 64'(irdy[i]), 64'd1);
          sbq[i].delete();
          prev_stall[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          chk("in_ready", i, 64'(irdy[i]), 64'(!(ovld[i] && !out_ready)));
          if (prev_stall[i]) begin
            chk("held out_valid", i, 64'(ovld[i]), 64'd1);
            chk("held result", i, res[i], prev_res[i]);
            chk("held cout", i, 64'(co[i]), 64'(prev_co[i]));
            chk("held overflow", i, 64'(of[i]), 64'(prev_of[i]));
          end
          if (ovld[i] && out_ready) begin
            if (sbq[i].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL d%0d unexpected output: got result %h, required no output", i, res[i]);
            end else begin
              e = sbq[i].pop_front();
              lat = int'((longint'($time) - e.t) / 10);
              chk("result", i, res[i], e.res);
              chk("cout", i, 64'(co[i]), 64'(e.co));
              chk("overflow", i, 64'(of[i]), 64'(e.ov));
              chk("latency", i, 64'(lat), 64'(STG[i] + stall[i] - e.snap));
            end
          end
          if (!irdy[i]) stall[i]++;
          prev_stall[i] = ovld[i] && !out_ready;
          prev_res[i]   = res[i];
          prev_co[i]    = co[i];
          prev_of[i]    = of[i];
        end
        if (done) begin
          for (int i = 0; i < 3; i++)
            chk("pending after drain", i, 64'(sbq[i].size()), 64'd0);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    step();
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom % 8)
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'd0;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h7F7F_7F7F_7FFF_FF7F;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int  sent;
    int  k;
    bit  newop;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; done = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    issue(64'd5, 64'd7, 1'b1, 1'b1);
    issue(64'd7, 64'd5, 1'b1, 1'b1);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    in_valid = 1'b0;
    repeat (10) step();

    // Ten back-to-back inputs with the consumer stalled for cycles 6..9.
    sent = 0; k = 0; newop = 1'b1;
    while (sent < 10 && k < 60) begin
      out_ready = !(k >= 6 && k <= 9);
      if (newop) begin
        a = rnd64(); b = rnd64(); sub = 1'($urandom % 2); cin = 1'($urandom % 2);
      end
      in_valid = 1'b1;
      @(negedge clk);
      newop = irdy[0];
      if (newop) sent++;
      step();
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();

    // Reset with three transactions in flight.
    issue(64'd1, 64'd2, 1'b0, 1'b0);
    issue(64'd3, 64'd4, 1'b1, 1'b0);
    issue(64'd9, 64'd8, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (10) step();

    repeat (3000) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a = rnd64(); b = rnd64(); sub = 1'($urandom % 2); cin = 1'($urandom % 2);
      step();
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    done = 1'b1;
    repeat (5) step();
    $display("FAIL monitor did not reach summary");
    $fatal(1, "monitor stalled");
  end

endmodule
